// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the boot-time instruction ROM loader: FSM state
// encodings, the NOP/zero word and the widest image header value.
package inst_rom_loader_pkg;

    // Loader FSM states. The image is received as a length header, then words.
    typedef enum logic [2:0] {
        LDR_LEN_HI = 3'd0,
        LDR_LEN_LO = 3'd1,
        LDR_WORD   = 3'd2,
        LDR_RUN    = 3'd3,
        LDR_ERR    = 3'd4
    } ldr_state_e;

    // Returned to the core whenever a fetch is not serviceable (acts as a NOP).
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Header word count is 16 bits; one extra bit lets comparisons against
    // 2^DEPTH_LOG2 be made without overflow.
    localparam int LenCmpW = 17;

    // Largest legal word count for a RAM of 2^depth_log2 words.
    function automatic logic [LenCmpW-1:0] max_words(input int depth_log2);
        return LenCmpW'(2 ** depth_log2);
    endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream loader channel and instruction fetch port of the ROM loader.
// The slave modport is the loader block; master is the producer/core side.
interface inst_rom_loader_if;

    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;

    modport master (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        output rom_ce_i,
        output rom_addr_i,
        input  rom_data_o
    );

    modport slave (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        input  rom_ce_i,
        input  rom_addr_i,
        output rom_data_o
    );

endinterface

// File: rtl/inst_ram.sv
// 32-bit instruction RAM: synchronous write, asynchronous read, no reset.
// Contents survive reset on purpose; the loader gates reads by word count.
module inst_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Write port: one word per cycle while the image streams in.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader and instruction ROM for the core. Receives a length-prefixed
// big-endian program image over a byte stream, holds the core in reset until
// the image is complete, then serves zero-wait fetches. Reload restarts the
// load from RUN or ERR without a global reset. DEPTH_LOG2 must be <= 16.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus,
    input  logic                  reload_i,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic [DEPTH_LOG2:0]   words_loaded_o
);

    localparam logic [LenCmpW-1:0] MaxWords = max_words(DEPTH_LOG2);

    ldr_state_e            state;
    logic [15:0]           len_q;
    logic [DEPTH_LOG2:0]   wcnt;
    logic [DEPTH_LOG2:0]   wcnt_inc;
    logic [1:0]            bcnt;
    logic [23:0]           held;
    logic [15:0]           len_nxt;
    logic                  fire;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  addr_in_range;
    logic                  addr_lsb_unused;

    assign fire     = bus.byte_valid_i & bus.byte_ready_o;
    assign len_nxt  = {len_q[15:8], bus.byte_data_i};
    assign wcnt_inc = wcnt + 1'b1;
    assign ram_we   = fire && (state == LDR_WORD) && (bcnt == 2'd3);

    // Loader FSM: header capture, byte-to-word assembly, run/error handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LDR_LEN_HI;
            len_q <= '0;
            wcnt  <= '0;
            bcnt  <= '0;
            held  <= '0;
        end else begin
            case (state)
                LDR_LEN_HI: begin
                    if (fire) begin
                        len_q[15:8] <= bus.byte_data_i;
                        state       <= LDR_LEN_LO;
                    end
                end
                LDR_LEN_LO: begin
                    if (fire) begin
                        len_q[7:0] <= bus.byte_data_i;
                        if (len_nxt == 16'd0 || {1'b0, len_nxt} > MaxWords)
                            state <= LDR_ERR;
                        else
                            state <= LDR_WORD;
                    end
                end
                LDR_WORD: begin
                    if (fire) begin
                        if (bcnt == 2'd3) begin
                            bcnt <= '0;
                            wcnt <= wcnt_inc;
                            if (LenCmpW'(wcnt_inc) == {1'b0, len_q})
                                state <= LDR_RUN;
                        end else begin
                            held <= {held[15:0], bus.byte_data_i};
                            bcnt <= bcnt + 2'd1;
                        end
                    end
                end
                LDR_RUN, LDR_ERR: begin
                    // Reload is only honoured once a load has finished or failed.
                    if (reload_i) begin
                        state <= LDR_LEN_HI;
                        len_q <= '0;
                        wcnt  <= '0;
                        bcnt  <= '0;
                        held  <= '0;
                    end
                end
                default: state <= LDR_LEN_HI;
            endcase
        end
    end

    inst_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wcnt[DEPTH_LOG2-1:0]),
        .wdata ({held, bus.byte_data_i}),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // Status outputs decode the registered state, never the live byte_valid.
    assign bus.byte_ready_o = (state == LDR_LEN_HI) || (state == LDR_LEN_LO) ||
                              (state == LDR_WORD);
    assign cpu_rst_o        = (state != LDR_RUN);
    assign load_done_o      = (state == LDR_RUN);
    assign load_err_o       = (state == LDR_ERR);
    assign words_loaded_o   = wcnt;

    // Fetch path: word index from the byte address; sub-word bits are ignored.
    assign rd_idx          = bus.rom_addr_i[DEPTH_LOG2+1:2];
    assign addr_in_range   = (bus.rom_addr_i[31:DEPTH_LOG2+2] == '0);
    assign addr_lsb_unused = ^bus.rom_addr_i[1:0];

    // Stale RAM words beyond the current image are masked by the wcnt check.
    assign bus.rom_data_o = (bus.rom_ce_i && (state == LDR_RUN) && addr_in_range &&
                             ({1'b0, rd_idx} < wcnt)) ? ram_rdata : ZeroWord;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: boot loads, error headers, reload,
// full-depth image and mid-load reset, checked with immediate assertions.
module tb_inst_rom_loader;

    localparam int DL2 = 10;

    logic          clk;
    logic          rst;
    logic          reload_i;
    logic          cpu_rst_o;
    logic          load_done_o;
    logic          load_err_o;
    logic [DL2:0]  words_loaded_o;

    int n_assert;
    int n_fail;
    logic last_cpu_rst;
    logic [7:0] img[$];

    inst_rom_loader_if ifc ();

    inst_rom_loader #(.DEPTH_LOG2(DL2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (ifc.slave),
        .reload_i       (reload_i),
        .cpu_rst_o      (cpu_rst_o),
        .load_done_o    (load_done_o),
        .load_err_o     (load_err_o),
        .words_loaded_o (words_loaded_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        ifc.rom_ce_i   = 1'b1;
        ifc.rom_addr_i = addr;
        #1;
        check(tag, ifc.rom_data_o, exp);
    endtask

    // Presents one byte for one cycle; leaves valid high so runs are back-to-back.
    task automatic send_byte(input logic [7:0] b, input bit chk_ready);
        ifc.byte_valid_i = 1'b1;
        ifc.byte_data_i  = b;
        @(negedge clk);
        last_cpu_rst = cpu_rst_o;
        if (chk_ready) check("ready_during_load", {31'd0, ifc.byte_ready_o}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Sends img; gap inserts an idle (valid low) cycle before every byte.
    task automatic send_img(input bit gap, input bit chk_ready);
        foreach (img[i]) begin
            if (gap) begin
                ifc.byte_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            send_byte(img[i], chk_ready);
        end
        ifc.byte_valid_i = 1'b0;
    endtask

    task automatic pulse_reload();
        reload_i = 1'b1;
        @(posedge clk);
        #1;
        reload_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[31:24]);
        img.push_back(w[23:16]);
        img.push_back(w[15:8]);
        img.push_back(w[7:0]);
    endtask

    task automatic build_n2();
        img = {};
        img.push_back(8'h00); img.push_back(8'h02);
        push_word(32'h3401_0010);
        push_word(32'h3402_0020);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        reload_i = 1'b0;
        ifc.byte_valid_i = 1'b0;
        ifc.byte_data_i  = 8'h00;
        ifc.rom_ce_i     = 1'b0;
        ifc.rom_addr_i   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset: core held, loader ready, fetches return NOP.
        check("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("rst_ready", {31'd0, ifc.byte_ready_o}, 32'd1);
        check("rst_done", {31'd0, load_done_o}, 32'd0);
        check("rst_err", {31'd0, load_err_o}, 32'd0);
        check("rst_words", 32'(words_loaded_o), 32'd0);
        fetch(32'h0, 32'h0, "rst_fetch0");
        fetch(32'h4, 32'h0, "rst_fetch4");

        // N=2 image, back-to-back bytes.
        build_n2();
        send_img(1'b0, 1'b0);
        check("b2b_cpu_rst_before_last", {31'd0, last_cpu_rst}, 32'd1);
        check("b2b_cpu_rst_after_last", {31'd0, cpu_rst_o}, 32'd0);
        check("b2b_done", {31'd0, load_done_o}, 32'd1);
        check("b2b_ready_run", {31'd0, ifc.byte_ready_o}, 32'd0);
        check("b2b_words", 32'(words_loaded_o), 32'd2);
        fetch(32'h0, 32'h3401_0010, "b2b_fetch0");
        fetch(32'h4, 32'h3402_0020, "b2b_fetch4");
        fetch(32'h6, 32'h3402_0020, "b2b_fetch6_lsb");
        fetch(32'h8, 32'h0, "b2b_fetch8");
        ifc.rom_ce_i = 1'b0;
        ifc.rom_addr_i = 32'h0;
        #1;
        check("b2b_ce_off", ifc.rom_data_o, 32'h0);

        // Reload from RUN, then same image with gaps and an ignored reload mid-load.
        pulse_reload();
        check("reload_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("reload_ready", {31'd0, ifc.byte_ready_o}, 32'd1);
        check("reload_words", 32'(words_loaded_o), 32'd0);
        fetch(32'h0, 32'h0, "reload_fetch0");
        img = {8'h00, 8'h02, 8'h34, 8'h01};
        send_img(1'b1, 1'b1);
        pulse_reload();
        check("midload_reload_ignored", {31'd0, ifc.byte_ready_o}, 32'd1);
        img = {8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
        send_img(1'b1, 1'b1);
        check("gap_done", {31'd0, load_done_o}, 32'd1);
        check("gap_words", 32'(words_loaded_o), 32'd2);
        fetch(32'h0, 32'h3401_0010, "gap_fetch0");
        fetch(32'h4, 32'h3402_0020, "gap_fetch4");

        // Zero-length header is rejected; reload recovers; N=1 load.
        pulse_reload();
        img = {8'h00, 8'h00};
        send_img(1'b0, 1'b0);
        check("n0_err", {31'd0, load_err_o}, 32'd1);
        check("n0_ready", {31'd0, ifc.byte_ready_o}, 32'd0);
        check("n0_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("n0_done", {31'd0, load_done_o}, 32'd0);
        pulse_reload();
        check("n0_reload_err", {31'd0, load_err_o}, 32'd0);
        check("n0_reload_ready", {31'd0, ifc.byte_ready_o}, 32'd1);
        img = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_img(1'b0, 1'b0);
        check("n1_done", {31'd0, load_done_o}, 32'd1);
        check("n1_words", 32'(words_loaded_o), 32'd1);
        fetch(32'h0, 32'hDEAD_BEEF, "n1_fetch0");
        fetch(32'h4, 32'h0, "n1_fetch4_stale_masked");

        // Oversize header, then a full-depth image.
        pulse_reload();
        img = {8'h04, 8'h01};
        send_img(1'b0, 1'b0);
        check("n401_err", {31'd0, load_err_o}, 32'd1);
        pulse_reload();
        img = {};
        img.push_back(8'h04); img.push_back(8'h00);
        for (int i = 0; i < 1024; i++) push_word(32'hC0DE_0000 | 32'(i));
        send_img(1'b0, 1'b0);
        check("full_done", {31'd0, load_done_o}, 32'd1);
        check("full_err", {31'd0, load_err_o}, 32'd0);
        check("full_words", 32'(words_loaded_o), 32'd1024);
        fetch(32'h0, 32'hC0DE_0000, "full_fetch0");
        fetch(32'h200, 32'hC0DE_0080, "full_fetch200");
        fetch(32'hFFC, 32'hC0DE_03FF, "full_fetchffc");
        fetch(32'h1000, 32'h0, "full_fetch_oob");

        // Reset asserted after 5 bytes of an N=2 load.
        pulse_reload();
        img = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_img(1'b0, 1'b0);
        ifc.rom_ce_i = 1'b1;
        ifc.rom_addr_i = 32'h0;
        rst = 1'b0;
        #1;
        check("arst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("arst_done", {31'd0, load_done_o}, 32'd0);
        check("arst_err", {31'd0, load_err_o}, 32'd0);
        check("arst_words", 32'(words_loaded_o), 32'd0);
        check("arst_fetch", ifc.rom_data_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_ready", {31'd0, ifc.byte_ready_o}, 32'd1);
        img = {};
        img.push_back(8'h00); img.push_back(8'h02);
        push_word(32'hAABB_CCDD);
        push_word(32'h1234_5678);
        send_img(1'b0, 1'b0);
        check("arst_reload_done", {31'd0, load_done_o}, 32'd1);
        check("arst_reload_words", 32'(words_loaded_o), 32'd2);
        fetch(32'h0, 32'hAABB_CCDD, "arst_fetch0");
        fetch(32'h4, 32'h1234_5678, "arst_fetch4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory block directly upstream of the CPU core's instruction port. It drives rom_data_i and consumes rom_addr_o/rom_ce_o.
- At boot it receives a program image over a byte-stream valid/ready interface and writes it into an internal word RAM.
- It holds the core in reset until the image is complete, then serves instruction fetches with zero-wait combinational reads.
- Supports reload without a global reset.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- byte_valid_i  in  1  loader byte available
- byte_data_i  in  8  loader byte
- byte_ready_o  out  1  block accepts a byte this cycle
- reload_i  in  1  single-cycle pulse: restart image load
- rom_ce_i  in  1  fetch enable from core
- rom_addr_i  in  32  byte address from core
- rom_data_o  out  32  instruction word to core
- cpu_rst_o  out  1  core reset, active-high (1 = hold core in reset)
- load_done_o  out  1  image loaded, core running
- load_err_o  out  1  header rejected
- words_loaded_o  out  DEPTH_LOG2+1  words written in current load

Behaviour:
- Image format: 2-byte big-endian word count N, then 4N bytes of instruction words, each word big-endian (first byte = bits 31:24).
- A byte transfers on the rising clk edge when byte_valid_i & byte_ready_o.
- States and transitions:
  - LEN_HI: accept high byte of N, go to LEN_LO.
  - LEN_LO: accept low byte of N. If N==0 or N>2^DEPTH_LOG2, go to ERR; else go to WORD.
  - WORD: byte counter 0..3 shifts bytes into a 24-bit holding register.
    - On the 4th byte, write {held[23:0], byte_data_i} to mem[wcnt], wcnt <= wcnt+1, byte counter <= 0.
    - If wcnt+1 == N, go to RUN.
  - RUN: core executing.
  - ERR: waits for reload_i or reset.
- byte_ready_o = 1 in LEN_HI, LEN_LO and WORD; 0 in RUN and ERR. It is a registered-state decode, not combinational on byte_valid_i.
- cpu_rst_o = 1 in every state except RUN. It first reads 0 in the cycle after the final byte is accepted.
- load_done_o = (state==RUN); load_err_o = (state==ERR).
- words_loaded_o = wcnt. It holds N while in RUN.
- reload_i:
  - In RUN or ERR: go to LEN_HI, clear wcnt and byte counter, cpu_rst_o = 1 from the next cycle.
  - In LEN_HI/LEN_LO/WORD: ignored.
- Fetch path (combinational, so the core's pipeline registers sample it on the same edge as the pc):
  - Index = rom_addr_i[DEPTH_LOG2+1:2]; rom_addr_i[1:0] are ignored.
  - rom_data_o = 0 (NOP) when any of: rom_ce_i==0, state!=RUN, index>=wcnt, or rom_addr_i above RAM range.
  - Otherwise rom_data_o = mem[index].
- Reset (rst==0, asynchronous, any time including mid-load):
  - state=LEN_HI, wcnt=0, byte counter=0, holding register=0, N=0.
  - Outputs: cpu_rst_o=1, byte_ready_o=1 once rst releases, load_done_o=0, load_err_o=0, words_loaded_o=0, rom_data_o=0.
  - RAM contents are not reset. Stale words are never visible because reads are gated by wcnt.
- No read/write conflict: writes occur only outside RUN, reads return 0 outside RUN.
- N == 2^DEPTH_LOG2 is legal and fills the RAM exactly. The wcnt width of DEPTH_LOG2+1 holds the full count.

Decomposition:
- Shared defines file: state encodings (LDR_LEN_HI, LDR_LEN_LO, LDR_WORD, LDR_RUN, LDR_ERR) and a ZeroWord constant reused for the NOP/zero output.
- Sub-module inst_ram: DEPTH_LOG2-parameterised RAM, 32-bit wide, synchronous write port, asynchronous read port.
- FSM, byte assembly and read gating stay in inst_rom_loader.

Test Plan:
- Reset release, no bytes → cpu_rst_o=1, byte_ready_o=1, rom_data_o=0 for any rom_addr_i with rom_ce_i=1.
- Load N=2: bytes 00 02 34 01 00 10 34 02 00 20, back-to-back valid → cpu_rst_o falls the cycle after byte 10. Then:
  - addr 0x0 → 0x34010010; addr 0x4 → 0x34020020; addr 0x8 → 0x00000000.
  - words_loaded_o=2.
- Same image with byte_valid_i toggling every other cycle → identical RAM contents, and byte_ready_o never drops before RUN.
- Header 00 00 → load_err_o=1, byte_ready_o=0, cpu_rst_o=1. Then reload_i pulse → LEN_HI, a valid N=1 image loads, load_done_o=1.
- Header N=0x0401 with DEPTH_LOG2=10 → ERR. N=0x0400 full image → RUN; addr 0xFFC returns the last word written.
- Assert rst low after 5 bytes of an N=2 load → all outputs at reset values immediately. A fresh full load then succeeds, with addr 0x4 returning the new second word.
